// File: rtl/charbuf_pkg.sv
// rtl/charbuf_pkg.sv - shared constants, state type and helpers for the character buffer writer
package charbuf_pkg;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam int DEF_COLS_LOG2 = 5;
    localparam int DEF_ROWS_LOG2 = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20);
    endfunction

endpackage

// File: rtl/charbuf_clear_seq.sv
// rtl/charbuf_clear_seq.sv - burst address counter for row and full-screen clears
module charbuf_clear_seq
    import charbuf_pkg::*;
#(
    parameter int COLS_LOG2 = DEF_COLS_LOG2,
    parameter int ROWS_LOG2 = DEF_ROWS_LOG2,
    parameter int ADDR_W    = COLS_LOG2 + ROWS_LOG2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_run,
    input  logic                 i_all,
    input  logic [ROWS_LOG2-1:0] i_row,
    output logic                 o_ce,
    output logic [ADDR_W-1:0]    o_addr,
    output logic                 o_done
);

    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_cnt;
    logic              w_last;

    // Row bursts only walk the column bits; the row comes from the cursor
    assign w_last = i_all ? (&r_cnt) : (&r_cnt[COLS_LOG2-1:0]);
    assign o_addr = i_all ? r_cnt : {i_row, r_cnt[COLS_LOG2-1:0]};
    assign o_ce   = i_run;
    assign o_done = i_run && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_start || !i_run || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/charbuf_term_writer.sv
// rtl/charbuf_term_writer.sv - terminal-style byte decoder and cursor driving the char buffer write port
module charbuf_term_writer
    import charbuf_pkg::*;
#(
    parameter int         COLS_LOG2      = DEF_COLS_LOG2,
    parameter int         ROWS_LOG2      = DEF_ROWS_LOG2,
    parameter int         ADDR_W         = COLS_LOG2 + ROWS_LOG2,
    parameter logic [7:0] FILL_CHAR      = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 wr_ce,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [7:0]           wr_data,
    output logic [COLS_LOG2-1:0] cur_col,
    output logic [ROWS_LOG2-1:0] cur_row,
    output logic                 busy
);

    localparam logic [COLS_LOG2-1:0] COL_ONE = COLS_LOG2'(1);
    localparam logic [ROWS_LOG2-1:0] ROW_ONE = ROWS_LOG2'(1);
    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLR_ALL : IDLE;

    state_t               r_state;
    logic                 r_wr_ce;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [7:0]           r_wr_data;
    logic [COLS_LOG2-1:0] r_cur_col;
    logic [ROWS_LOG2-1:0] r_cur_row;

    logic                 w_accept;
    logic                 w_start;
    logic [COLS_LOG2-1:0] w_col_dec;
    logic                 w_seq_ce;
    logic [ADDR_W-1:0]    w_seq_addr;
    logic                 w_seq_done;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign wr_ce     = r_wr_ce;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cur_col   = r_cur_col;
    assign cur_row   = r_cur_row;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_col_dec = r_cur_col - COL_ONE;
    assign w_start   = w_accept && ((is_printable(in_data) && (&r_cur_col)) ||
                                    (in_data == CH_LF) || (in_data == CH_FF));

    charbuf_clear_seq #(
        .COLS_LOG2 (COLS_LOG2),
        .ROWS_LOG2 (ROWS_LOG2),
        .ADDR_W    (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_run   (r_state != IDLE),
        .i_all   (r_state == CLR_ALL),
        .i_row   (r_cur_row),
        .o_ce    (w_seq_ce),
        .o_addr  (w_seq_addr),
        .o_done  (w_seq_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RST_STATE;
            r_wr_ce   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_cur_col <= '0;
            r_cur_row <= '0;
        end else begin
            r_wr_ce <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (is_printable(in_data)) begin
                            r_wr_ce   <= 1'b1;
                            r_wr_addr <= {r_cur_row, r_cur_col};
                            r_wr_data <= in_data;
                            // Wrapping off the right edge clears the freshly entered row
                            if (&r_cur_col) begin
                                r_cur_col <= '0;
                                r_cur_row <= r_cur_row + ROW_ONE;
                                r_state   <= CLR_ROW;
                            end else begin
                                r_cur_col <= r_cur_col + COL_ONE;
                            end
                        end else begin
                            case (in_data)
                                CH_LF: begin
                                    r_cur_col <= '0;
                                    r_cur_row <= r_cur_row + ROW_ONE;
                                    r_state   <= CLR_ROW;
                                end
                                CH_CR: r_cur_col <= '0;
                                CH_BS: begin
                                    if (|r_cur_col) begin
                                        r_cur_col <= w_col_dec;
                                        r_wr_ce   <= 1'b1;
                                        r_wr_addr <= {r_cur_row, w_col_dec};
                                        r_wr_data <= FILL_CHAR;
                                    end
                                end
                                CH_FF: begin
                                    r_cur_col <= '0;
                                    r_cur_row <= '0;
                                    r_state   <= CLR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLR_ROW, CLR_ALL: begin
                    r_wr_ce   <= w_seq_ce;
                    r_wr_addr <= w_seq_addr;
                    r_wr_data <= FILL_CHAR;
                    if (w_seq_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
